scpu_mem_resp: RTL and testbench

SCPU_MEM_RESP -- requirements
Module: scpu_mem_resp

---
 rtl/scpu_mem_resp_pkg.sv | 17 +
 rtl/scpu_ram.sv | 26 ++
 rtl/scpu_mem_resp.sv | 108 ++++++++++
 tb/tb_scpu_mem_resp.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scpu_mem_resp_pkg.sv
// Shared definitions for the memory responder: FSM encodings and default parameters.
package scpu_mem_resp_pkg;

    localparam int DEPTH_DEFAULT    = 256;
    localparam int WAIT_CYC_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic addr_in_range(input logic [7:0] addr, input int depth);
        return int'({24'd0, addr}) < depth;
    endfunction

endpackage

// File: rtl/scpu_ram.sv
// DEPTH x 8 storage, no reset; read data registered on the access edge, writes pass the data through.
module scpu_ram #(
    parameter int DEPTH = 256
) (
    input  logic       clk,
    input  logic       en,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata     <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/scpu_mem_resp.sv
// Single-outstanding CPU memory responder with programmable wait states and a response handshake.
//  state   | meaning
//  IDLE    | ready for a request (req_ready=1)
//  WAIT    | counting down wait states; access happens when the counter reaches 0
//  RESP    | response presented (rsp_valid=1) until rsp_ready
module scpu_mem_resp
    import scpu_mem_resp_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int WAIT_CYC = WAIT_CYC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] txn_cnt
);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       lat_wr;
    logic [7:0] lat_addr;
    logic [7:0] lat_wdata;
    logic       rdata_vld;
    logic       in_range;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_rdata;

    assign in_range = addr_in_range(lat_addr, DEPTH);

    // Gated by state, so an asynchronous reset in WAIT also blocks a pending write.
    assign ram_en = (state == ST_WAIT) && (wait_cnt == 4'd0) && in_range;
    assign ram_we = ram_en && lat_wr;

    // RAM output is not reset; the zero/out-of-range case is selected here instead.
    assign rsp_rdata = rdata_vld ? ram_rdata : 8'h00;

    scpu_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (lat_addr),
        .wdata (lat_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rdata_vld <= 1'b0;
            txn_cnt   <= 8'h00;
            lat_wr    <= 1'b0;
            lat_addr  <= 8'h00;
            lat_wdata <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_wr    <= req_wr;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        wait_cnt  <= 4'(WAIT_CYC);
                        req_ready <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        rsp_err   <= !in_range;
                        rdata_vld <= in_range;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        txn_cnt   <= txn_cnt + 8'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scpu_mem_resp.sv
// Randomized bench for scpu_mem_resp: two instances (default config, and WAIT_CYC=0/DEPTH=200) against a queue-free array model.
module tb_scpu_mem_resp;

    logic       clk;
    logic       rst_n;
    logic       req_valid [2];
    logic       req_wr    [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];
    logic       rsp_ready [2];
    logic       req_ready [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];
    logic       rsp_err   [2];
    logic [7:0] txn_cnt   [2];

    int         depth_m [2] = '{256, 200};
    int         wait_m  [2] = '{2, 0};
    logic [7:0] mem_m   [2][256];
    bit         known   [2][256];
    int         cnt_m   [2];

    int n_cmp = 0;
    int n_err = 0;

    scpu_mem_resp u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[0]),
        .req_ready (req_ready[0]),
        .req_wr    (req_wr[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .rsp_valid (rsp_valid[0]),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata[0]),
        .rsp_err   (rsp_err[0]),
        .txn_cnt   (txn_cnt[0])
    );

    scpu_mem_resp #(.DEPTH(200), .WAIT_CYC(0)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid[1]),
        .req_ready (req_ready[1]),
        .req_wr    (req_wr[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .rsp_valid (rsp_valid[1]),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata[1]),
        .rsp_err   (rsp_err[1]),
        .txn_cnt   (txn_cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // One complete transaction, with the expected response taken from the model.
    task automatic do_txn(input int d, input bit wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input int hold, input bit early);
        int         lat;
        int         guard;
        bit         chk_data;
        logic [7:0] exp_d;
        logic       exp_e;
        if (int'(addr) >= depth_m[d]) begin
            exp_e = 1'b1; exp_d = 8'h00; chk_data = 1'b1;
        end else if (wr) begin
            exp_e = 1'b0; exp_d = wdata; chk_data = 1'b1;
            mem_m[d][addr] = wdata; known[d][addr] = 1'b1;
        end else begin
            exp_e = 1'b0; exp_d = mem_m[d][addr]; chk_data = known[d][addr];
        end
        @(negedge clk);
        rsp_ready[d] = early;
        req_valid[d] = 1'b1; req_wr[d] = wr; req_addr[d] = addr; req_wdata[d] = wdata;
        guard = 0;
        while (req_ready[d] !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 20) begin
            n_err++;
            $display("FAIL accept_timeout dut%0d: req_ready=%b required 1", d, req_ready[d]);
        end
        @(posedge clk); #1;
        // Garbage request held during WAIT must be ignored.
        req_wr[d] = 1'($urandom); req_addr[d] = 8'($urandom); req_wdata[d] = 8'($urandom);
        lat = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        req_valid[d] = 1'b0;
        n_cmp++;
        if (lat != wait_m[d] + 1) begin
            n_err++;
            $display("FAIL latency dut%0d addr=%h: got %0d cycles required %0d", d, addr, lat, wait_m[d] + 1);
        end
        n_cmp++;
        if (rsp_err[d] !== exp_e) begin
            n_err++;
            $display("FAIL rsp_err dut%0d addr=%h wr=%b: got %b required %b", d, addr, wr, rsp_err[d], exp_e);
        end
        if (chk_data) begin
            n_cmp++;
            if (rsp_rdata[d] !== exp_d) begin
                n_err++;
                $display("FAIL rsp_rdata dut%0d addr=%h wr=%b: got %h required %h", d, addr, wr, rsp_rdata[d], exp_d);
            end
        end
        n_cmp++;
        if (req_ready[d] !== 1'b0) begin
            n_err++;
            $display("FAIL req_ready_in_resp dut%0d: got %b required 0", d, req_ready[d]);
        end
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                req_valid[d] = 1'b1; req_wr[d] = 1'($urandom); req_addr[d] = 8'($urandom);
                req_wdata[d] = 8'($urandom);
                @(posedge clk); #1;
                n_cmp++;
                if (rsp_valid[d] !== 1'b1 || rsp_err[d] !== exp_e || (chk_data && rsp_rdata[d] !== exp_d)
                    || req_ready[d] !== 1'b0 || txn_cnt[d] !== 8'(cnt_m[d] % 256)) begin
                    n_err++;
                    $display("FAIL hold dut%0d cycle %0d: got v=%b d=%h e=%b rdy=%b cnt=%h required v=1 d=%h e=%b rdy=0 cnt=%h",
                             d, i, rsp_valid[d], rsp_rdata[d], rsp_err[d], req_ready[d], txn_cnt[d],
                             exp_d, exp_e, 8'(cnt_m[d] % 256));
                end
            end
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
        end
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        cnt_m[d]++;
        n_cmp++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            n_err++;
            $display("FAIL handshake dut%0d: got rsp_valid=%b req_ready=%b required 0/1", d, rsp_valid[d], req_ready[d]);
        end
        n_cmp++;
        if (txn_cnt[d] !== 8'(cnt_m[d] % 256)) begin
            n_err++;
            $display("FAIL txn_cnt dut%0d: got %h required %h", d, txn_cnt[d], 8'(cnt_m[d] % 256));
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            cnt_m[d] = 0;
            n_cmp++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 8'h00
                || rsp_err[d] !== 1'b0 || txn_cnt[d] !== 8'h00) begin
                n_err++;
                $display("FAIL reset_outputs dut%0d: got rdy=%b v=%b d=%h e=%b cnt=%h required 1 0 00 0 00",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d], txn_cnt[d]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_write_read();
        do_txn(0, 1'b1, 8'h10, 8'hA5, 0, 1'b0);
        do_txn(0, 1'b0, 8'h10, 8'h00, 0, 1'b0);
    endtask

    task automatic test_out_of_range();
        do_txn(1, 1'b1, 8'h48, 8'h5A, 0, 1'b0);
        do_txn(1, 1'b1, 8'hC7, 8'h99, 0, 1'b0);
        do_txn(1, 1'b0, 8'hC8, 8'h00, 0, 1'b0);
        do_txn(1, 1'b1, 8'hC8, 8'h55, 0, 1'b0);
        do_txn(1, 1'b1, 8'hFF, 8'h66, 1, 1'b0);
        do_txn(1, 1'b0, 8'hC7, 8'h00, 0, 1'b0);
        do_txn(1, 1'b0, 8'h48, 8'h00, 0, 1'b0);
    endtask

    task automatic test_hold();
        do_txn(0, 1'b0, 8'h10, 8'h00, 5, 1'b0);
        do_txn(1, 1'b1, 8'hD0, 8'h11, 5, 1'b0);
    endtask

    task automatic test_early_ready();
        do_txn(0, 1'b1, 8'h30, 8'h77, 0, 1'b1);
        do_txn(0, 1'b0, 8'h30, 8'h00, 0, 1'b1);
        do_txn(1, 1'b0, 8'h48, 8'h00, 0, 1'b1);
    endtask

    task automatic test_reset_in_wait();
        do_txn(0, 1'b1, 8'h20, 8'h00, 0, 1'b0);
        @(negedge clk);
        req_valid[0] = 1'b1; req_wr[0] = 1'b1; req_addr[0] = 8'h20; req_wdata[0] = 8'h3C;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) cnt_m[d] = 0;
        n_cmp++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 8'h00
            || rsp_err[0] !== 1'b0 || txn_cnt[0] !== 8'h00) begin
            n_err++;
            $display("FAIL reset_in_wait dut0: got rdy=%b v=%b d=%h e=%b cnt=%h required 1 0 00 0 00",
                     req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0], txn_cnt[0]);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        do_txn(0, 1'b0, 8'h20, 8'h00, 0, 1'b0);
        do_txn(0, 1'b0, 8'h10, 8'h00, 0, 1'b0);
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 1; i <= 256; i++) begin
            do_txn(1, 1'($urandom), 8'($urandom), 8'($urandom), 0, 1'($urandom));
            if (i == 255) begin
                n_cmp++;
                if (txn_cnt[1] !== 8'hFF) begin
                    n_err++;
                    $display("FAIL wrap_255: got %h required ff", txn_cnt[1]);
                end
            end
        end
        n_cmp++;
        if (txn_cnt[1] !== 8'h00) begin
            n_err++;
            $display("FAIL wrap_256: got %h required 00", txn_cnt[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int         d;
            logic [7:0] a;
            d = i % 2;
            a = 8'($urandom_range(0, 15)) + (($urandom_range(0, 1) == 1) ? 8'hC0 : 8'h00);
            do_txn(d, 1'($urandom), a, 8'($urandom), $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_wr[d] = 1'b0; req_addr[d] = 8'h00;
            req_wdata[d] = 8'h00; rsp_ready[d] = 1'b0; cnt_m[d] = 0;
            for (int a = 0; a < 256; a++) begin
                mem_m[d][a] = 8'h00;
                known[d][a] = 1'b0;
            end
        end
        test_reset();
        test_write_read();
        test_out_of_range();
        test_hold();
        test_early_ready();
        test_reset_in_wait();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
